floatli_exp_normalizer: RTL



---
 rtl/floatli_pkg.sv | 40 ++++
 rtl/floatli_pipe_reg.sv | 64 ++++++
 rtl/floatli_exp_normalizer.sv | 117 +++++++++++
 3 files changed

// File: rtl/floatli_pkg.sv
// Shared constants, width helpers and payload types for the floatli exponent
// normaliser pipeline.
package floatli_pkg;

    localparam int FL_EXP_WIDTH = 11;
    localparam int FL_MAN_WIDTH = 52;
    localparam int FL_TAG_WIDTH = 1;
    localparam int FL_INT_WIDTH = FL_EXP_WIDTH + 3;

    function automatic int bias(input int exp_width);
        return (32'sd1 <<< (exp_width - 32'sd1)) - 32'sd1;
    endfunction

    function automatic int sum_width(input int exp_width);
        return exp_width + 32'sd2;
    endfunction

    function automatic int int_width(input int exp_width);
        return exp_width + 32'sd3;
    endfunction

    function automatic int shift_width(input int man_width);
        return $clog2(32'sd2 * man_width + 32'sd3);
    endfunction

    function automatic int adj_width(input int man_width);
        return shift_width(man_width) + 32'sd1;
    endfunction

    // Largest useful right shift: the full product width.
    function automatic int max_shift(input int man_width);
        return 32'sd2 * man_width + 32'sd2;
    endfunction

    typedef struct packed {
        logic [FL_INT_WIDTH-1:0] e;
        logic [FL_TAG_WIDTH-1:0] tag;
    } s1_payload_t;

endpackage

// File: rtl/floatli_pipe_reg.sv
// Valid/ready register slice with synchronous flush; one per pipeline stage.
// The valid bit is the only control state, data loads only on acceptance.
module floatli_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             in_ready_s;
    logic             accept_s;

    // Slice can take data when empty or when its content leaves this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !valid_r || out_ready;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Valid bit: flush wins, then new data, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Data register holds unless a transfer is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            data_r <= in_data;
        end else begin
            data_r <= data_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule

// File: rtl/floatli_exp_normalizer.sv
// Two-stage exponent normaliser: unbias + normalisation adjust, then classify
// into normal / overflow / tiny with a saturated denormalisation shift.
module floatli_exp_normalizer
    import floatli_pkg::*;
#(
    parameter int EXP_WIDTH = FL_EXP_WIDTH,
    parameter int MAN_WIDTH = FL_MAN_WIDTH,
    parameter int TAG_WIDTH = FL_TAG_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [sum_width(EXP_WIDTH)-1:0]     exp_sum_i,
    input  logic [adj_width(MAN_WIDTH)-1:0]     norm_adj_i,
    input  logic [TAG_WIDTH-1:0]                tag_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [EXP_WIDTH-1:0]                exp_o,
    output logic [shift_width(MAN_WIDTH)-1:0]   denorm_shift_o,
    output logic                                overflow_o,
    output logic                                tiny_o,
    output logic [TAG_WIDTH-1:0]                tag_o,
    output logic                                busy_o
);

    localparam int SUM_WIDTH   = sum_width(EXP_WIDTH);
    localparam int INT_WIDTH   = int_width(EXP_WIDTH);
    localparam int SHIFT_WIDTH = shift_width(MAN_WIDTH);
    localparam int ADJ_WIDTH   = adj_width(MAN_WIDTH);
    localparam int S2_WIDTH    = EXP_WIDTH + SHIFT_WIDTH + 2 + TAG_WIDTH;

    localparam logic [INT_WIDTH-1:0] BIAS_C = INT_WIDTH'(bias(EXP_WIDTH));
    localparam logic [INT_WIDTH-1:0] ONE_C  = INT_WIDTH'(1);
    localparam logic [INT_WIDTH-1:0] MAX_C  = INT_WIDTH'((1 << EXP_WIDTH) - 1);
    localparam logic [INT_WIDTH-1:0] SAT_C  = INT_WIDTH'(max_shift(MAN_WIDTH));

    s1_payload_t             s1_in_s;
    s1_payload_t             s1_out_s;
    logic                    s1_valid_s;
    logic                    s2_ready_s;
    logic [INT_WIDTH-1:0]    adj_ext_s;
    logic [INT_WIDTH-1:0]    e_s;
    logic [INT_WIDTH-1:0]    diff_s;
    logic [EXP_WIDTH-1:0]    cls_exp_s;
    logic [SHIFT_WIDTH-1:0]  cls_shift_s;
    logic                    cls_ovf_s;
    logic                    cls_tiny_s;
    logic [S2_WIDTH-1:0]     s2_in_s;
    logic [S2_WIDTH-1:0]     s2_out_s;
    logic                    s2_valid_s;

    // Stage-1 arithmetic: modular INT_WIDTH sum read back as two's complement.
    always_comb begin
        adj_ext_s = {{(INT_WIDTH-ADJ_WIDTH){norm_adj_i[ADJ_WIDTH-1]}}, norm_adj_i};
        e_s       = {{(INT_WIDTH-SUM_WIDTH){1'b0}}, exp_sum_i} - BIAS_C + adj_ext_s;
        s1_in_s.e   = e_s;
        s1_in_s.tag = tag_i;
    end

    floatli_pipe_reg #(
        .WIDTH ($bits(s1_payload_t))
    ) u_stage1 (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (flush_i),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_out_s)
    );

    // Classification is done ahead of the stage-2 register so outputs are flops.
    always_comb begin
        cls_exp_s   = {EXP_WIDTH{1'b0}};
        cls_shift_s = {SHIFT_WIDTH{1'b0}};
        cls_ovf_s   = 1'b0;
        cls_tiny_s  = 1'b0;
        diff_s      = ONE_C - s1_out_s.e;
        if (!s1_out_s.e[INT_WIDTH-1] && (s1_out_s.e >= MAX_C)) begin
            cls_ovf_s = 1'b1;
            cls_exp_s = {EXP_WIDTH{1'b1}};
        end else if (s1_out_s.e[INT_WIDTH-1] || (s1_out_s.e == {INT_WIDTH{1'b0}})) begin
            cls_tiny_s = 1'b1;
            if (diff_s > SAT_C) begin
                cls_shift_s = SAT_C[SHIFT_WIDTH-1:0];
            end else begin
                cls_shift_s = diff_s[SHIFT_WIDTH-1:0];
            end
        end else begin
            cls_exp_s = s1_out_s.e[EXP_WIDTH-1:0];
        end
        s2_in_s = {cls_exp_s, cls_shift_s, cls_ovf_s, cls_tiny_s, s1_out_s.tag};
    end

    floatli_pipe_reg #(
        .WIDTH (S2_WIDTH)
    ) u_stage2 (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (flush_i),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (s2_valid_s),
        .out_ready (out_ready_i),
        .out_data  (s2_out_s)
    );

    assign {exp_o, denorm_shift_o, overflow_o, tiny_o, tag_o} = s2_out_s;
    assign out_valid_o = s2_valid_s;
    assign busy_o      = s1_valid_s | s2_valid_s;

endmodule
